ps2_paddle_ctrl: RTL and testbench

Scancode sequencer between the PS/2 receive path and the Pong game logic. Consumes the raw byte stream (one byte per `key_valid` pulse) and parses PS/2 set-2 make/break/extended sequences with a prefix state machine. Maintains a held-key map for the game keys, resolves conflicting up/down presses per player, and issues paddle move commands once per frame tick. Emits single-cycle pulses for pause and start.

---
 rtl/ps2_paddle_ctrl.sv | 151 +++++++++++++++
 tb/tb_ps2_paddle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_paddle_ctrl.sv
// PS/2 set-2 scancode sequencer for Pong: parses make/break/extended prefixes,
// keeps a held-key map, and issues per-frame paddle moves plus pause/start pulses.
module ps2_paddle_ctrl #(
    parameter int unsigned TICK_DIV       = 833333,
    parameter int unsigned PREFIX_TIMEOUT = 50000
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    output logic [5:0] key_held,
    output logic [1:0] p1_move,
    output logic [1:0] p2_move,
    output logic       move_tick,
    output logic       pause_pulse,
    output logic       start_pulse,
    output logic       proto_err
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OW = $clog2(PREFIX_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_E0   = 2'd1;
    localparam logic [1:0] ST_F0   = 2'd2;
    localparam logic [1:0] ST_E0F0 = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] to_cnt;
    logic          last_dir1;
    logic          last_dir2;

    logic          is_e0;
    logic          is_f0;
    logic          term;
    logic          ext;
    logic          brk;
    logic [5:0]    hit;
    logic [5:0]    make_set;
    logic [5:0]    brk_clr;

    function automatic logic [1:0] move_of(input logic up, input logic dn, input logic ld);
        if (up && dn)
            return ld ? 2'b10 : 2'b01;
        else if (up)
            return 2'b01;
        else if (dn)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // A terminating byte is any non-prefix byte; its meaning comes from the prefix state.
    always_comb begin
        is_e0    = (key_data == 8'hE0);
        is_f0    = (key_data == 8'hF0);
        term     = key_valid && !is_e0 && !is_f0;
        ext      = (state == ST_E0) || (state == ST_E0F0);
        brk      = (state == ST_F0) || (state == ST_E0F0);
        hit      = '0;
        case ({ext, key_data})
            9'h01D:  hit = 6'b000001;
            9'h01B:  hit = 6'b000010;
            9'h175:  hit = 6'b000100;
            9'h172:  hit = 6'b001000;
            9'h04D:  hit = 6'b010000;
            9'h029:  hit = 6'b100000;
            default: hit = '0;
        endcase
        make_set = (term && !brk) ? (hit & ~key_held) : '0;
        brk_clr  = (term && brk) ? hit : '0;
    end

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            to_cnt      <= '0;
            last_dir1   <= 1'b0;
            last_dir2   <= 1'b0;
            key_held    <= '0;
            p1_move     <= '0;
            p2_move     <= '0;
            move_tick   <= 1'b0;
            pause_pulse <= 1'b0;
            start_pulse <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            move_tick <= 1'b0;
            proto_err <= 1'b0;

            // Moves sample the registered held map, so a byte on the same edge is not seen.
            if (tick_cnt == TW'(TICK_DIV - 1)) begin
                tick_cnt  <= '0;
                move_tick <= 1'b1;
                p1_move   <= move_of(key_held[0], key_held[1], last_dir1);
                p2_move   <= move_of(key_held[2], key_held[3], last_dir2);
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (key_valid) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (is_e0)
                            state <= ST_E0;
                        else if (is_f0)
                            state <= ST_F0;
                        else
                            state <= ST_IDLE;
                    end
                    ST_E0: begin
                        if (is_f0) begin
                            state <= ST_E0F0;
                        end else begin
                            state     <= ST_IDLE;
                            proto_err <= is_e0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        proto_err <= is_e0 || is_f0;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                if (to_cnt == OW'(PREFIX_TIMEOUT - 1)) begin
                    state     <= ST_IDLE;
                    to_cnt    <= '0;
                    proto_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            key_held    <= (key_held | make_set) & ~brk_clr;
            pause_pulse <= make_set[4];
            start_pulse <= make_set[5];
            if (make_set[0])
                last_dir1 <= 1'b0;
            else if (make_set[1])
                last_dir1 <= 1'b1;
            if (make_set[2])
                last_dir2 <= 1'b0;
            else if (make_set[3])
                last_dir2 <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Bench for ps2_paddle_ctrl: directed sequences plus random byte streams,
// compared every cycle against a transaction-level model of the key rules.
module tb_ps2_paddle_ctrl;

    localparam int unsigned TD = 8;
    localparam int unsigned PT = 4;

    logic       inclock = 1'b0;
    logic       resetn  = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data  = 8'h00;
    logic [5:0] key_held;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       move_tick;
    logic       pause_pulse;
    logic       start_pulse;
    logic       proto_err;

    ps2_paddle_ctrl #(.TICK_DIV(TD), .PREFIX_TIMEOUT(PT)) dut (
        .inclock     (inclock),
        .resetn      (resetn),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .key_held    (key_held),
        .p1_move     (p1_move),
        .p2_move     (p2_move),
        .move_tick   (move_tick),
        .pause_pulse (pause_pulse),
        .start_pulse (start_pulse),
        .proto_err   (proto_err)
    );

    always #5 inclock = ~inclock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pause  = 0;

    // Reference model state
    logic [5:0] m_held;
    logic       m_ld1, m_ld2;
    logic [1:0] m_p1, m_p2;
    logic       m_tick, m_pause, m_start, m_err;
    int         m_cyc;
    int         m_idle;
    logic [7:0] m_pfx[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int key_bit(input logic ext, input logic [7:0] code);
        logic [8:0] codes [6];
        codes = '{9'h01D, 9'h01B, 9'h175, 9'h172, 9'h04D, 9'h029};
        for (int i = 0; i < 6; i++)
            if (codes[i] == {ext, code})
                return i;
        return -1;
    endfunction

    function automatic logic [1:0] ref_move(input logic up, input logic dn, input logic ld);
        if (up && !dn) return 2'b01;
        if (dn && !up) return 2'b10;
        if (up && dn)  return ld ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic model_edge(input logic rst_n, input logic v, input logic [7:0] d);
        logic [5:0] ph;
        logic       pl1, pl2, ext, brk;
        int         k;
        if (!rst_n) begin
            m_held = '0; m_ld1 = 0; m_ld2 = 0; m_p1 = 0; m_p2 = 0;
            m_tick = 0; m_pause = 0; m_start = 0; m_err = 0;
            m_cyc = 0; m_idle = 0; m_pfx.delete();
            return;
        end
        ph = m_held; pl1 = m_ld1; pl2 = m_ld2;
        m_tick = 0; m_pause = 0; m_start = 0; m_err = 0;
        m_cyc++;
        if (m_cyc % TD == 0) begin
            m_tick = 1;
            m_p1 = ref_move(ph[0], ph[1], pl1);
            m_p2 = ref_move(ph[2], ph[3], pl2);
        end
        if (v) begin
            m_idle = 0;
            if (d == 8'hE0) begin
                if (m_pfx.size() == 0) m_pfx.push_back(d);
                else begin m_err = 1; m_pfx.delete(); end
            end else if (d == 8'hF0) begin
                if (m_pfx.size() == 0 || (m_pfx.size() == 1 && m_pfx[0] == 8'hE0))
                    m_pfx.push_back(d);
                else begin m_err = 1; m_pfx.delete(); end
            end else begin
                ext = 0; brk = 0;
                foreach (m_pfx[i]) begin
                    if (m_pfx[i] == 8'hE0) ext = 1;
                    if (m_pfx[i] == 8'hF0) brk = 1;
                end
                m_pfx.delete();
                k = key_bit(ext, d);
                if (k >= 0) begin
                    if (brk) begin
                        m_held[k] = 1'b0;
                    end else if (!ph[k]) begin
                        m_held[k] = 1'b1;
                        if (k == 4) m_pause = 1;
                        if (k == 5) m_start = 1;
                        if (k == 0) m_ld1 = 0;
                        if (k == 1) m_ld1 = 1;
                        if (k == 2) m_ld2 = 0;
                        if (k == 3) m_ld2 = 1;
                    end
                end
            end
        end else if (m_pfx.size() != 0) begin
            m_idle++;
            if (m_idle == PT) begin
                m_err = 1; m_idle = 0; m_pfx.delete();
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic v, input logic [7:0] d);
        resetn = rst_n; key_valid = v; key_data = d;
        @(posedge inclock);
        #1;
        model_edge(rst_n, v, d);
        if (pause_pulse) n_pause++;
        check("key_held",    key_held,    m_held);
        check("p1_move",     p1_move,     m_p1);
        check("p2_move",     p2_move,     m_p2);
        check("move_tick",   move_tick,   m_tick);
        check("pause_pulse", pause_pulse, m_pause);
        check("start_pulse", start_pulse, m_start);
        check("proto_err",   proto_err,   m_err);
        key_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [7:0] b;
        int         r;
        pool = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h4D, 8'h29, 8'hE0, 8'hF0, 8'hE0, 8'h00};

        do_reset();
        check("reset_held", key_held, 6'd0);
        idle(20);

        send(8'h1D); idle(9);
        check("w_held", key_held[0], 1'b1);
        check("w_move", p1_move, 2'b01);
        send(8'hF0); send(8'h1D); idle(9);
        check("w_rel_move", p1_move, 2'b00);

        send(8'h1D); idle(2); send(8'h1B); idle(9);
        check("ws_move", p1_move, 2'b10);
        send(8'hF0); send(8'h1B); idle(9);
        check("ws_rel_move", p1_move, 2'b01);
        send(8'hF0); send(8'h1D); idle(2);

        send(8'hE0); send(8'h75); idle(9);
        check("up2_held", key_held[2], 1'b1);
        check("up2_move", p2_move, 2'b01);
        send(8'h75); idle(2);
        check("bare75", key_held[2], 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(9);
        check("up2_rel", key_held[2], 1'b0);

        n_pause = 0;
        send(8'h4D); send(8'h4D); idle(1); send(8'h4D);
        send(8'hF0); send(8'h4D); send(8'h4D); idle(2);
        check("pause_count", n_pause, 2);
        send(8'hF0); send(8'h4D);

        send(8'hE0); idle(5); send(8'h1D); idle(2);
        check("timeout_then_make", key_held[0], 1'b1);
        send(8'hF0); send(8'hE0); idle(2);
        send(8'h29); send(8'hF0); send(8'h29);

        send(8'hE0); do_reset(); send(8'h72); idle(2);
        check("reset_discard", key_held[3], 1'b0);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 10) begin
                idle($urandom_range(3, 6));
            end else if (r < 40) begin
                idle(1);
            end else begin
                b = pool[$urandom_range(0, 9)];
                if (b == 8'h00) b = 8'($urandom_range(0, 255));
                send(b);
            end
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
